// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and limits for the fetch/data memory port arbiter.
// Port tags travel through the read-return pipeline to steer mem_rdata.
package mem_port_arbiter_pkg;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
    } tag_t;

    localparam int MEM_LATENCY_MIN  = 1;
    localparam int MEM_LATENCY_MAX  = 4;
    localparam int STARVE_LIMIT_MIN = 1;
    localparam int STARVE_LIMIT_MAX = 15;
    localparam int STARVE_W         = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core ports, the arbiter and the unified memory.
// slave = arbiter view, master = core/memory view.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 12
);
    logic                      i_req;
    logic [ADDRESS_BITS-1:0]   i_address;
    logic                      i_ready;
    logic                      i_flush;
    logic                      i_valid;
    logic [DATA_WIDTH-1:0]     i_data;

    logic                      d_req;
    logic                      d_we;
    logic [DATA_WIDTH/8-1:0]   d_byte_en;
    logic [ADDRESS_BITS-1:0]   d_address;
    logic [DATA_WIDTH-1:0]     d_wdata;
    logic                      d_ready;
    logic                      d_valid;
    logic [DATA_WIDTH-1:0]     d_data;

    logic                      mem_en;
    logic                      mem_we;
    logic [DATA_WIDTH/8-1:0]   mem_byte_en;
    logic [ADDRESS_BITS-1:0]   mem_address;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    modport slave (
        input  i_req, i_address, i_flush,
        output i_ready, i_valid, i_data,
        input  d_req, d_we, d_byte_en, d_address, d_wdata,
        output d_ready, d_valid, d_data,
        output mem_en, mem_we, mem_byte_en, mem_address, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req, i_address, i_flush,
        input  i_ready, i_valid, i_data,
        output d_req, d_we, d_byte_en, d_address, d_wdata,
        input  d_ready, d_valid, d_data,
        input  mem_en, mem_we, mem_byte_en, mem_address, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_tag_pipe.sv
// Fixed-depth {valid, port} shift register tracking reads in flight.
// Entries of flush_port_i are invalidated wherever they sit, output stage included.
module arb_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  tag_t  tag_i,
    input  logic  flush_i,
    input  port_e flush_port_i,
    output tag_t  tag_o
);

    tag_t [DEPTH-1:0] tag_q;
    tag_t [DEPTH-1:0] tag_d;

    function automatic tag_t squash(tag_t t, logic flush, port_e p);
        tag_t r;
        r = t;
        if (flush && (t.port == p)) r.valid = 1'b0;
        return r;
    endfunction

    // The incoming tag bypasses the flush so a same-cycle grant survives.
    always_comb begin
        tag_d    = '0;
        tag_d[0] = tag_i;
        for (int k = 1; k < DEPTH; k++) begin
            tag_d[k] = squash(tag_q[k-1], flush_i, flush_port_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tag_q <= '0;
        else        tag_q <= tag_d;
    end

    assign tag_o = squash(tag_q[DEPTH-1], flush_i, flush_port_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data port wins unless fetch has starved for
// STARVE_LIMIT cycles; reads return to their owner MEM_LATENCY cycles later.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 12,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clock,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);

    if (MEM_LATENCY < MEM_LATENCY_MIN || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY out of range 1..4");
    end
    if (STARVE_LIMIT < STARVE_LIMIT_MIN || STARVE_LIMIT > STARVE_LIMIT_MAX) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_LIMIT out of range 1..15");
    end

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                starved;
    logic                fetch_win, data_win;
    tag_t                tag_in, tag_ret;

    // Grants are gated by reset so nothing issues while reset is held.
    always_comb begin
        starved   = (starve_q == STARVE_W'(STARVE_LIMIT));
        fetch_win = reset && bus.i_req && (!bus.d_req || starved);
        data_win  = reset && bus.d_req && !fetch_win;
    end

    assign bus.i_ready = fetch_win;
    assign bus.d_ready = data_win;

    always_comb begin
        bus.mem_en      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_byte_en = '0;
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        if (fetch_win) begin
            bus.mem_en      = 1'b1;
            bus.mem_address = bus.i_address;
        end else if (data_win) begin
            bus.mem_en      = 1'b1;
            bus.mem_we      = bus.d_we;
            bus.mem_byte_en = bus.d_byte_en;
            bus.mem_address = bus.d_address;
            bus.mem_wdata   = bus.d_wdata;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.i_req || fetch_win) starve_d = '0;
        else if (!starved)           starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) starve_q <= '0;
        else        starve_q <= starve_d;
    end

    always_comb begin
        tag_in.valid = fetch_win || (data_win && !bus.d_we);
        tag_in.port  = fetch_win ? PORT_FETCH : PORT_DATA;
    end

    arb_tag_pipe #(.DEPTH(MEM_LATENCY)) u_tag_pipe (
        .clk          (clock),
        .rst_n        (reset),
        .tag_i        (tag_in),
        .flush_i      (bus.i_flush),
        .flush_port_i (PORT_FETCH),
        .tag_o        (tag_ret)
    );

    always_comb begin
        bus.i_valid = reset && tag_ret.valid && (tag_ret.port == PORT_FETCH);
        bus.d_valid = reset && tag_ret.valid && (tag_ret.port == PORT_DATA);
        bus.i_data  = bus.i_valid ? bus.mem_rdata : '0;
        bus.d_data  = bus.d_valid ? bus.mem_rdata : '0;
    end

endmodule
